ram: RTL and testbench



---
 rtl/ram.sv | 76 +++++++
 tb/tb_ram.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ram.sv
// Single-clock dual-port word memory: a read/write data port plus a read-only fetch port.
// Optional macro RAM_FETCH_BYPASS_EN forwards data-port write data to a colliding fetch.
module ram #(
    parameter int DATA_SIZE    = 32,
    parameter int ADDRESS_SIZE = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    read_write,
    input  logic [ADDRESS_SIZE-1:0] address,
    input  logic [DATA_SIZE-1:0]    data_in,
    output logic [DATA_SIZE-1:0]    data_out,
    input  logic [ADDRESS_SIZE-1:0] fetch_address,
    output logic [DATA_SIZE-1:0]    fetch_out
);

    localparam int DEPTH = 1 << ADDRESS_SIZE;

    // Left unreset so a simulation preload survives reset.
    logic [DATA_SIZE-1:0] mem [0:DEPTH-1];

    logic                 wr_en;
    logic                 rd_en;
    logic                 fetch_hit;
    logic [DATA_SIZE-1:0] data_q;
    logic [DATA_SIZE-1:0] fetch_q;

    always_comb begin
        wr_en     = enable && !read_write && !rst;
        rd_en     = enable && read_write;
        fetch_hit = wr_en && (fetch_address == address);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[address] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (rd_en) begin
            data_q <= mem[address];
        end
    end

`ifdef RAM_FETCH_BYPASS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_q <= '0;
        end else if (fetch_hit) begin
            fetch_q <= data_in;
        end else begin
            fetch_q <= mem[fetch_address];
        end
    end
`else
    // Read-before-write: a colliding fetch sees the pre-write word.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_q <= '0;
        end else begin
            fetch_q <= mem[fetch_address];
        end
    end

    logic unused_fetch_hit;
    assign unused_fetch_hit = fetch_hit;
`endif

    assign data_out  = data_q;
    assign fetch_out = fetch_q;

endmodule

// File: tb/tb_ram.sv
// Scoreboard bench for ram: expectations come from a behavioural memory model.
module tb_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        read_write;
    logic [15:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [15:0] fetch_address;
    logic [31:0] fetch_out;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] d;
        logic [31:0] f;
        bit          cf;
        string       tag;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] m [int];
    logic [31:0] mdout;

`ifdef RAM_FETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    ram #(.DATA_SIZE(32), .ADDRESS_SIZE(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .read_write(read_write),
        .address(address), .data_in(data_in), .data_out(data_out),
        .fetch_address(fetch_address), .fetch_out(fetch_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "/data"}, data_out, e.d);
        if (e.cf) check({e.tag, "/fetch"}, fetch_out, e.f);
    endtask

    task automatic cyc(input string tag, input bit en, input bit rw,
                       input logic [15:0] a, input logic [31:0] d, input logic [15:0] fa);
        exp_t e;
        bit   wr;
        wr    = en && !rw;
        e.tag = tag;
        if (en && rw) mdout = m.exists(int'(a)) ? m[int'(a)] : 32'hx;
        e.d = mdout;
        if (wr && fa == a && BYPASS) begin
            e.f = d; e.cf = 1'b1;
        end else begin
            e.cf = m.exists(int'(fa));
            e.f  = e.cf ? m[int'(fa)] : 32'h0;
        end
        sb.push_back(e);
        if (wr) m[int'(a)] = d;
        rst = 1'b0; enable = en; read_write = rw; address = a; data_in = d; fetch_address = fa;
        @(posedge clk); #1;
        pop_check();
    endtask

    task automatic do_reset(input string tag);
        exp_t e;
        e.tag = tag; e.d = 32'h0; e.f = 32'h0; e.cf = 1'b1;
        sb.push_back(e);
        mdout = 32'h0;
        rst = 1'b1; enable = 1'b1; read_write = 1'b0; address = 16'd7;
        data_in = 32'h0BAD0BAD; fetch_address = 16'd7;
        @(posedge clk); #1;
        pop_check();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; read_write = 1'b1;
        address = '0; data_in = '0; fetch_address = '0;
        do_reset("reset0");
        // reset-cycle write to address 7 must be suppressed
        cyc("rd7_after_rst", 1'b1, 1'b1, 16'd7, 32'h0, 16'd0);
        check("rst_write_suppressed", data_out === 32'h0BAD0BAD ? 32'h1 : 32'h0, 32'h0);

        cyc("pre0", 1'b1, 1'b0, 16'd0, 32'h11111111, 16'd0);
        cyc("pre1", 1'b1, 1'b0, 16'd1, 32'h22222222, 16'd0);
        cyc("pre2", 1'b1, 1'b0, 16'd2, 32'h33333333, 16'd0);
        cyc("pre3", 1'b1, 1'b0, 16'd3, 32'h44444444, 16'd0);

        cyc("rd0_0", 1'b1, 1'b1, 16'd0, 32'h0, 16'd0);
        check("tp_rd0", data_out, 32'h11111111);
        cyc("rd1_3", 1'b1, 1'b1, 16'd1, 32'h0, 16'd3);
        check("tp_fetch3", fetch_out, 32'h44444444);
        cyc("rd2_2", 1'b1, 1'b1, 16'd2, 32'h0, 16'd2);
        cyc("rd3_1", 1'b1, 1'b1, 16'd3, 32'h0, 16'd1);
        check("tp_fetch1", fetch_out, 32'h22222222);

        do_reset("reset1");
        cyc("rd1_after_rst", 1'b1, 1'b1, 16'd1, 32'h0, 16'd1);
        check("tp_mem1_kept", data_out, 32'h22222222);

        cyc("wr5", 1'b1, 1'b0, 16'd5, 32'hDEADBEEF, 16'd2);
        check("tp_wr5_hold", data_out, 32'h22222222);
        cyc("rd5", 1'b1, 1'b1, 16'd5, 32'h0, 16'd5);
        check("tp_rd5", data_out, 32'hDEADBEEF);

        cyc("idle", 1'b0, 1'b0, 16'd0, 32'hFFFFFFFF, 16'd2);
        check("tp_idle_fetch2", fetch_out, 32'h33333333);
        cyc("idle_rdhold", 1'b0, 1'b1, 16'd1, 32'h0, 16'd0);
        cyc("rd0_after_idle", 1'b1, 1'b1, 16'd0, 32'h0, 16'd0);
        check("tp_mem0_kept", data_out, 32'h11111111);

        cyc("wr3_collide", 1'b1, 1'b0, 16'd3, 32'hCAFEF00D, 16'd3);
        check("tp_collide", fetch_out, BYPASS ? 32'hCAFEF00D : 32'h44444444);
        cyc("fetch3_next", 1'b0, 1'b1, 16'd0, 32'h0, 16'd3);
        check("tp_fetch3_new", fetch_out, 32'hCAFEF00D);

        cyc("wr_top", 1'b1, 1'b0, 16'hFFFF, 32'h0000FFFF, 16'd1);
        cyc("rd_top", 1'b1, 1'b1, 16'hFFFF, 32'h0, 16'hFFFF);
        check("tp_top_data", data_out, 32'h0000FFFF);
        check("tp_top_fetch", fetch_out, 32'h0000FFFF);
        cyc("rd0_after_top", 1'b1, 1'b1, 16'd0, 32'h0, 16'd0);
        check("tp_mem0_untouched", fetch_out, 32'h11111111);

        // same-word reads on both ports return identical data
        for (int i = 0; i < 4; i++) begin
            cyc("dual_same", 1'b1, 1'b1, 16'(i), 32'h0, 16'(i));
            check("dual_same_eq", fetch_out, data_out);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
